// File: rtl/player_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : player_ctl_if
// Brief    : Key/frame inputs and sprite position outputs of the player
//            motion controller.
// Revision : 1.0
// ============================================================================
interface player_ctl_if;
    logic        v_tick;
    logic        left;
    logic        right;
    logic        jump;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [1:0]  state;
    logic        facing;

    modport master (
        output v_tick, left, right, jump,
        input  xpos, ypos, state, facing
    );

    modport slave (
        input  v_tick, left, right, jump,
        output xpos, ypos, state, facing
    );
endinterface
`default_nettype wire

// File: rtl/player_ctl.sv
`default_nettype none
// ============================================================================
// Module   : player_ctl
// Brief    : Per-frame player sprite motion: saturated walking, gravity jump
//            with floor/ceiling clamping, animation state and facing flag.
// Revision : 1.0
// ============================================================================
module player_ctl #(
    parameter int X_INIT  = 400,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 760,
    parameter int Y_MIN   = 0,
    parameter int Y_FLOOR = 500,
    parameter int STEP    = 4,
    parameter int JUMP_V  = 16,
    parameter int GRAVITY = 1,
    parameter int V_MAX   = 15,
    parameter int VW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    player_ctl_if.slave bus
);

    // Two guard bits above the 12-bit coordinates keep sums and differences
    // from wrapping before they are clamped.
    localparam int c_PW = 14;
    typedef logic signed [c_PW-1:0] pos_t;

    localparam pos_t c_X_MIN_W     = pos_t'(X_MIN);
    localparam pos_t c_X_MAX_W     = pos_t'(X_MAX);
    localparam pos_t c_Y_MIN_W     = pos_t'(Y_MIN);
    localparam pos_t c_Y_FLOOR_W   = pos_t'(Y_FLOOR);
    localparam pos_t c_STEP_W      = pos_t'(STEP);
    localparam pos_t c_GRAVITY_W   = pos_t'(GRAVITY);
    localparam pos_t c_V_MAX_W     = pos_t'(V_MAX);
    localparam pos_t c_VY_TAKEOFF  = -pos_t'(JUMP_V);

    localparam logic [11:0] c_X_INIT  = 12'(X_INIT);
    localparam logic [11:0] c_X_MIN   = 12'(X_MIN);
    localparam logic [11:0] c_X_MAX   = 12'(X_MAX);
    localparam logic [11:0] c_Y_MIN   = 12'(Y_MIN);
    localparam logic [11:0] c_Y_FLOOR = 12'(Y_FLOOR);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WALK_L = 2'd1;
    localparam logic [1:0] c_WALK_R = 2'd2;
    localparam logic [1:0] c_AIR    = 2'd3;

    typedef enum logic [0:0] {
        ST_GROUND = 1'b0,
        ST_AIR    = 1'b1
    } vstate_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                 r_v_tick_d;
    logic                 r_jump_d;
    logic                 r_jump_req;
    logic [11:0]          r_x;
    logic [11:0]          r_y;
    logic signed [VW-1:0] r_vy;
    vstate_t              r_vstate;
    logic [1:0]           r_state;
    logic                 r_facing;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic                 w_strobe;
    logic                 w_jump_edge;
    logic                 w_jump_req_nxt;
    logic [11:0]          w_x_nxt;
    logic [11:0]          w_y_nxt;
    logic signed [VW-1:0] w_vy_nxt;
    vstate_t              w_vstate_nxt;
    logic [1:0]           w_state_nxt;
    logic                 w_facing_nxt;
    logic [1:0]           w_walk;

    pos_t                 w_x_ext;
    pos_t                 w_x_dec;
    pos_t                 w_x_inc;
    pos_t                 w_vy_ext;
    pos_t                 w_vy_grav;
    pos_t                 w_y_n;

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        w_x_ext   = $signed({2'b00, r_x});
        w_x_dec   = w_x_ext - c_STEP_W;
        w_x_inc   = w_x_ext + c_STEP_W;
        w_vy_ext  = pos_t'(r_vy);
        w_vy_grav = w_vy_ext + c_GRAVITY_W;
        w_y_n     = $signed({2'b00, r_y}) + w_vy_ext;
    end

    assign w_strobe    = bus.v_tick & ~r_v_tick_d;
    assign w_jump_edge = bus.jump & ~r_jump_d;

    // ------------------------------------------------------------------
    // Next-state / output decision
    // ------------------------------------------------------------------
    always_comb begin
        w_jump_req_nxt = r_jump_req;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_vy_nxt       = r_vy;
        w_vstate_nxt   = r_vstate;
        w_state_nxt    = r_state;
        w_facing_nxt   = r_facing;
        w_walk         = c_IDLE;

        if (w_strobe) begin
            // Any pending request is spent by this frame, taken or not.
            w_jump_req_nxt = 1'b0;

            case ({bus.left, bus.right})
                2'b10: begin
                    w_x_nxt      = (w_x_dec < c_X_MIN_W) ? c_X_MIN : w_x_dec[11:0];
                    w_facing_nxt = 1'b0;
                    w_walk       = c_WALK_L;
                end
                2'b01: begin
                    w_x_nxt      = (w_x_inc > c_X_MAX_W) ? c_X_MAX : w_x_inc[11:0];
                    w_facing_nxt = 1'b1;
                    w_walk       = c_WALK_R;
                end
                default: w_walk = c_IDLE;
            endcase

            case (r_vstate)
                ST_GROUND: begin
                    if (r_jump_req || w_jump_edge) begin
                        w_vy_nxt     = c_VY_TAKEOFF[VW-1:0];
                        w_vstate_nxt = ST_AIR;
                    end
                end
                ST_AIR: begin
                    if (w_y_n >= c_Y_FLOOR_W) begin
                        w_y_nxt      = c_Y_FLOOR;
                        w_vy_nxt     = '0;
                        w_vstate_nxt = ST_GROUND;
                    end else if (w_y_n < c_Y_MIN_W) begin
                        w_y_nxt  = c_Y_MIN;
                        w_vy_nxt = '0;
                    end else begin
                        w_y_nxt  = w_y_n[11:0];
                        w_vy_nxt = (w_vy_grav > c_V_MAX_W) ? c_V_MAX_W[VW-1:0]
                                                           : w_vy_grav[VW-1:0];
                    end
                end
                default: w_vstate_nxt = ST_GROUND;
            endcase

            w_state_nxt = (w_vstate_nxt == ST_AIR) ? c_AIR : w_walk;
        end else if (w_jump_edge) begin
            w_jump_req_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v_tick_d <= 1'b1;
            r_jump_d   <= 1'b0;
            r_jump_req <= 1'b0;
            r_x        <= c_X_INIT;
            r_y        <= c_Y_FLOOR;
            r_vy       <= '0;
            r_vstate   <= ST_GROUND;
            r_state    <= c_IDLE;
            r_facing   <= 1'b1;
        end else begin
            r_v_tick_d <= bus.v_tick;
            r_jump_d   <= bus.jump;
            r_jump_req <= w_jump_req_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_vy       <= w_vy_nxt;
            r_vstate   <= w_vstate_nxt;
            r_state    <= w_state_nxt;
            r_facing   <= w_facing_nxt;
        end
    end

    assign bus.xpos   = r_x;
    assign bus.ypos   = r_y;
    assign bus.state  = r_state;
    assign bus.facing = r_facing;

endmodule
`default_nettype wire

// File: tb/tb_player_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_ctl
// Brief    : Scoreboard bench for player_ctl; two instances (default ceiling
//            and Y_MIN=400) share the same key and frame stimulus.
// Revision : 1.0
// ============================================================================
module tb_player_ctl;

    logic clk = 1'b0;
    logic rst;
    logic v_tick;
    logic left;
    logic right;
    logic jump;

    always #5 clk = ~clk;

    player_ctl_if bus_a ();
    player_ctl_if bus_b ();

    assign bus_a.v_tick = v_tick;
    assign bus_a.left   = left;
    assign bus_a.right  = right;
    assign bus_a.jump   = jump;
    assign bus_b.v_tick = v_tick;
    assign bus_b.left   = left;
    assign bus_b.right  = right;
    assign bus_b.jump   = jump;

    player_ctl u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    player_ctl #(.Y_MIN(400)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        int x;
        int y;
        int st;
        int fc;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state, index 0 = u_dut_a, 1 = u_dut_b.
    int m_x   [2];
    int m_y   [2];
    int m_vy  [2];
    int m_air [2];
    int m_h   [2];
    int m_fc  [2];
    int ymin  [2] = '{0, 400};
    bit pend;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_x[i]   = 400;
            m_y[i]   = 500;
            m_vy[i]  = 0;
            m_air[i] = 0;
            m_h[i]   = 0;
            m_fc[i]  = 1;
        end
        pend = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        exp_t e;
        int   yn;
        for (int i = 0; i < 2; i++) begin
            if (left && !right) begin
                m_x[i]  = (m_x[i] - 4 < 0) ? 0 : m_x[i] - 4;
                m_fc[i] = 0;
                m_h[i]  = 1;
            end else if (right && !left) begin
                m_x[i]  = (m_x[i] + 4 > 760) ? 760 : m_x[i] + 4;
                m_fc[i] = 1;
                m_h[i]  = 2;
            end else begin
                m_h[i] = 0;
            end
            if (m_air[i] == 0) begin
                if (pend) begin
                    m_vy[i]  = -16;
                    m_air[i] = 1;
                end
            end else begin
                yn = m_y[i] + m_vy[i];
                if (yn >= 500) begin
                    m_y[i]   = 500;
                    m_vy[i]  = 0;
                    m_air[i] = 0;
                end else if (yn < ymin[i]) begin
                    m_y[i]  = ymin[i];
                    m_vy[i] = 0;
                end else begin
                    m_y[i]  = yn;
                    m_vy[i] = (m_vy[i] + 1 > 15) ? 15 : m_vy[i] + 1;
                end
            end
            e.x  = m_x[i];
            e.y  = m_y[i];
            e.st = (m_air[i] != 0) ? 3 : m_h[i];
            e.fc = m_fc[i];
            exp_q.push_back(e);
        end
        pend = 1'b0;
    endtask

    task automatic check_dut(input int i, input string tag, input exp_t e);
        logic [11:0] x, y;
        logic [1:0]  st;
        logic        fc;
        x  = (i == 0) ? bus_a.xpos   : bus_b.xpos;
        y  = (i == 0) ? bus_a.ypos   : bus_b.ypos;
        st = (i == 0) ? bus_a.state  : bus_b.state;
        fc = (i == 0) ? bus_a.facing : bus_b.facing;
        check_val($sformatf("%s[%0d].xpos", tag, i),   32'(x),  32'(e.x));
        check_val($sformatf("%s[%0d].ypos", tag, i),   32'(y),  32'(e.y));
        check_val($sformatf("%s[%0d].state", tag, i),  32'(st), 32'(e.st));
        check_val($sformatf("%s[%0d].facing", tag, i), 32'(fc), 32'(e.fc));
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (exp_q.size() == 0) begin
                check_val({tag, ".queue_empty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_dut(i, tag, e);
            end
        end
    endtask

    task automatic check_model(input string tag);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e.x  = m_x[i];
            e.y  = m_y[i];
            e.st = (m_air[i] != 0) ? 3 : m_h[i];
            e.fc = m_fc[i];
            check_dut(i, tag, e);
        end
    endtask

    task automatic set_jump(input logic v);
        if (v && !jump) pend = 1'b1;
        jump = v;
    endtask

    // Called on a falling clock edge; returns on a falling clock edge.
    task automatic frame(input int hold);
        v_tick = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        pop_compare("frame");
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check_model("hold");
        end
        @(negedge clk);
        v_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".xa"}, 32'(bus_a.xpos),   32'd400);
        check_val({tag, ".ya"}, 32'(bus_a.ypos),   32'd500);
        check_val({tag, ".sa"}, 32'(bus_a.state),  32'd0);
        check_val({tag, ".fa"}, 32'(bus_a.facing), 32'd1);
        check_val({tag, ".xb"}, 32'(bus_b.xpos),   32'd400);
        check_val({tag, ".yb"}, 32'(bus_b.ypos),   32'd500);
        check_val({tag, ".sb"}, 32'(bus_b.state),  32'd0);
    endtask

    int exp_sat [3] = '{756, 760, 760};

    initial begin
        rst    = 1'b0;
        v_tick = 1'b1;
        left   = 1'b0;
        right  = 1'b0;
        jump   = 1'b0;
        model_reset();

        // Release reset with v_tick already high: no update expected.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_vals("rst_vhigh");
        v_tick = 1'b0;
        @(negedge clk);

        // Long v_tick pulse counts as one frame.
        frame(5);

        // Walk right up to the right limit.
        right = 1'b1;
        repeat (88) frame(0);
        check_val("walk_r.x752", 32'(bus_a.xpos), 32'd752);
        for (int k = 0; k < 3; k++) begin
            frame(0);
            check_val($sformatf("sat_r%0d", k), 32'(bus_a.xpos), 32'(exp_sat[k]));
            check_val($sformatf("sat_r%0d.state", k), 32'(bus_a.state), 32'd2);
        end

        // Both keys: no motion, facing unchanged.
        left = 1'b1;
        repeat (2) frame(0);
        check_val("both.state", 32'(bus_a.state), 32'd0);
        check_val("both.facing", 32'(bus_a.facing), 32'd1);
        right = 1'b0;
        frame(0);
        right = 1'b1;
        frame(0);
        check_val("both.facing_l", 32'(bus_a.facing), 32'd0);
        left  = 1'b0;
        right = 1'b0;

        // Short jump pulse between strobes.
        @(negedge clk);
        set_jump(1'b1);
        repeat (2) @(negedge clk);
        set_jump(1'b0);
        @(negedge clk);
        frame(0);
        check_val("takeoff.y", 32'(bus_a.ypos), 32'd500);
        check_val("takeoff.state", 32'(bus_a.state), 32'd3);
        for (int f = 1; f <= 34; f++) begin
            frame(0);
            if (f == 1)             check_val("arc.f1", 32'(bus_a.ypos), 32'd484);
            if (f == 16 || f == 17) check_val("arc.peak", 32'(bus_a.ypos), 32'd364);
            if (f == 32)            check_val("arc.f32", 32'(bus_a.ypos), 32'd484);
            if (f == 33)            check_val("arc.f33", 32'(bus_a.ypos), 32'd499);
            if (f == 34) begin
                check_val("arc.land_y", 32'(bus_a.ypos), 32'd500);
                check_val("arc.land_st", 32'(bus_a.state), 32'd0);
            end
        end

        // Jump held through landing: single take-off only.
        set_jump(1'b1);
        @(negedge clk);
        repeat (40) frame(0);
        check_val("held.ground", 32'(bus_a.state), 32'd0);

        // Release, then re-press coincident with a strobe.
        set_jump(1'b0);
        repeat (2) @(negedge clk);
        set_jump(1'b1);
        frame(0);
        check_val("repress.state", 32'(bus_a.state), 32'd3);
        repeat (33) frame(0);

        // Press during the last air frame: landing wins, request dropped.
        set_jump(1'b0);
        @(negedge clk);
        set_jump(1'b1);
        @(negedge clk);
        set_jump(1'b0);
        @(negedge clk);
        frame(0);
        check_val("land_req.y", 32'(bus_a.ypos), 32'd500);
        frame(0);
        check_val("land_req.st", 32'(bus_a.state), 32'd0);

        // Asynchronous reset mid-descent.
        repeat (30) frame(0);
        set_jump(1'b1);
        @(negedge clk);
        set_jump(1'b0);
        @(negedge clk);
        frame(0);
        repeat (20) frame(0);
        #3;
        rst = 1'b0;
        #1;
        check_reset_vals("rst_async");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        right = 1'b1;
        frame(0);
        check_val("post_rst.x", 32'(bus_a.xpos), 32'd404);
        right = 1'b0;
        frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_ctl.md
# player_ctl

Parametrised per-frame motion controller for the player sprite, replacing the fixed-path rectangle controller. It sits between the keyboard decoder and the sprite drawer, sampling left/right/jump keys once per frame on the vsync rising edge. It produces saturated horizontal movement, gravity-driven jumps with floor and ceiling clamping, a 2-bit animation state and a facing flag. All outputs are registered.

## Interface
- X_INIT, 400: x position after reset.
- X_MIN, 0 / X_MAX, 760: inclusive horizontal limits for xpos.
- Y_MIN, 0 / Y_FLOOR, 500: ceiling and floor y; ypos after reset = Y_FLOOR.
- STEP, 4: horizontal pixels per frame.
- JUMP_V, 16: take-off speed, px/frame, upward.
- GRAVITY, 1: velocity increment per frame.
- V_MAX, 15: maximum downward speed.
- VW, 8: signed velocity register width; must hold -JUMP_V and V_MAX+GRAVITY.
- clk  in  1  single system clock (pixel clock domain).
- rst  in  1  asynchronous, active-low reset.
- v_tick  in  1  frame tick (vsync level); the rising edge defines a frame.
- left, right, jump  in  1 each  key-held levels, synchronous to clk.
- xpos  out  12  sprite x, unsigned.
- ypos  out  12  sprite y, unsigned; grows downward.
- state  out  2  0 IDLE, 1 WALK_L, 2 WALK_R, 3 AIR.
- facing  out  1  1 = right, 0 = left.

## Operation
- Frame strobe: v_tick & ~v_tick_d, where v_tick_d is a register. All position, velocity and state updates occur only on strobe cycles; otherwise all registers hold.
- Jump request latch: a rising edge of jump (jump & ~jump_d) sets jump_req at any cycle. jump_req clears on every strobe, whether or not it is consumed. Holding jump does not retrigger it; a new press is required.
- Horizontal, on each strobe in any vertical state:
  - left only: x = max(x - STEP, X_MIN); facing = 0.
  - right only: x = min(x + STEP, X_MAX); facing = 1.
  - both or neither: x and facing unchanged.
  - The subtraction is computed wide enough that it cannot underflow below 0 before clamping.
- Vertical FSM:
  - GROUND, strobe with (jump_req or a jump edge in the same cycle): vy = -JUMP_V, go to AIR. y is unchanged on the take-off frame.
  - AIR, strobe: y_n = y + vy, computed signed and wide; then vy = min(vy + GRAVITY, V_MAX).
  - If y_n >= Y_FLOOR: y = Y_FLOOR, vy = 0, go to GROUND (landing).
  - Else if y_n < Y_MIN: y = Y_MIN, vy = 0, stay in AIR (head bump).
  - Else: y = y_n.
- state output: AIR whenever the FSM is in AIR. Otherwise it reflects the horizontal decision of the last strobe: WALK_L, WALK_R or IDLE.
- Reset values: xpos = X_INIT, ypos = Y_FLOOR, vy = 0, FSM GROUND, state = IDLE, facing = 1, jump_req = 0, jump_d = 0, v_tick_d = 1. Setting v_tick_d to 1 means a v_tick already high at reset release produces no strobe.

## Timing
- v_tick is first sampled high at clock edge n: the outputs change at edge n and are visible from edge n onward. Latency is one clock from the v_tick rise.
- Exactly one update per v_tick rising edge, regardless of how long v_tick stays high.
- A jump press and release entirely between two strobes is still honoured at the next strobe.
- A jump edge coinciding with a strobe is consumed by that strobe.
- A jump press while in AIR is discarded at the next strobe; there is no buffered double-jump.
- Landing and a new jump request in the same strobe: the landing is taken and the request is cleared. A jump needs a fresh press after touchdown.
- Reset asserted mid-jump: all registers return to reset values immediately and asynchronously. The first strobe after release behaves as from power-up.

## Test plan
- Reset with v_tick held high, then release -> no update. xpos=400, ypos=500, state=0, facing=1 until the next v_tick rising edge.
- right held for 3 frames from x=752 -> xpos 756, 760, 760 (saturates). state=2 on each frame.
- left and right both held -> xpos unchanged, state=0, facing keeps its previous value.
- Single jump pulse of 2 cycles mid-frame, defaults -> the next strobe sets AIR with y=500:
  - ypos=484 after the 1st subsequent frame.
  - peak 364 after the 16th and 17th frames.
  - 484 after the 32nd, 499 after the 33rd.
  - 500 with state back to ground after the 34th.
- jump held continuously through the landing -> no second take-off. A release followed by a re-press launches again on the next strobe.
- Y_MIN=400, jump from floor -> ypos clamps to 400 with vy=0, then falls back and lands at 500. rst pulsed low mid-descent -> xpos=400, ypos=500, state=0 immediately.
